// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked sequential ALU. Add/sub, bitwise logic and signed
//            compares finish one cycle after accept. Multiply, unsigned
//            divide and unsigned remainder run on an iterative datapath and
//            take BIT_WIDTH iterations.
// Option   : Define ALU_SEQ_MULDIV_EN to build the iterative
//            multiply/divide datapath. Without it, the MUL/DIVU/REMU codes
//            finish in one cycle and are reported as undefined (err=1).
// Ports    : clk       rising-edge clock
//            reset     asynchronous, active-high reset
//            inValid   request valid          inReady  request accepted
//            func[4:0] operation code         dataIn1  operand A
//            dataIn2   operand B              outValid result valid
//            outReady  result consumed        dataOut  result
//            compTrue  compare outcome        err      bad code or /0
// Revision : 1.0 - first release
// ============================================================================
module alu_seq #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [4:0]           func,
  input  logic [BIT_WIDTH-1:0] dataIn1,
  input  logic [BIT_WIDTH-1:0] dataIn2,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [BIT_WIDTH-1:0] dataOut,
  output logic                 compTrue,
  output logic                 err
);

  // Operation codes
  localparam logic [4:0] c_funcAdd  = 5'b00000;
  localparam logic [4:0] c_funcSub  = 5'b00001;
  localparam logic [4:0] c_funcAnd  = 5'b00100;
  localparam logic [4:0] c_funcOr   = 5'b00101;
  localparam logic [4:0] c_funcXor  = 5'b00110;
  localparam logic [4:0] c_funcNand = 5'b01100;
  localparam logic [4:0] c_funcNor  = 5'b01101;
  localparam logic [4:0] c_funcXnor = 5'b01110;
  localparam logic [4:0] c_funcF    = 5'b10000;
  localparam logic [4:0] c_funcEq   = 5'b10001;
  localparam logic [4:0] c_funcLt   = 5'b10010;
  localparam logic [4:0] c_funcLte  = 5'b10011;
  localparam logic [4:0] c_funcT    = 5'b11000;
  localparam logic [4:0] c_funcNe   = 5'b11001;
  localparam logic [4:0] c_funcGte  = 5'b11010;
  localparam logic [4:0] c_funcGt   = 5'b11011;
`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [4:0] c_funcMul  = 5'b01000;
  localparam logic [4:0] c_funcDivu = 5'b01010;
  localparam logic [4:0] c_funcRemu = 5'b01011;

  // Iteration counter width; must be able to hold BIT_WIDTH itself.
  localparam int CNT_W = $clog2(BIT_WIDTH) + 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_SEQ_MULDIV_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } stateT;

  stateT                r_state;
  logic                 r_inReady;
  logic                 r_outValid;
  logic [BIT_WIDTH-1:0] r_dataOut;
  logic                 r_compTrue;
  logic                 r_err;

  assign inReady  = r_inReady;
  assign outValid = r_outValid;
  assign dataOut  = r_dataOut;
  assign compTrue = r_compTrue;
  assign err      = r_err;

  // --------------------------------------------------------------------------
  // Single-cycle result, evaluated on the live inputs and captured on accept.
  // --------------------------------------------------------------------------
  logic                 w_equal;
  logic                 w_lessThan;
  logic [BIT_WIDTH-1:0] w_result;
  logic                 w_compare;
  logic                 w_error;
`ifdef ALU_SEQ_MULDIV_EN
  logic                 w_iterative;
`endif

  assign w_equal    = (dataIn1 == dataIn2);
  assign w_lessThan = ($signed(dataIn1) < $signed(dataIn2));

  always_comb begin
    w_result  = '0;
    w_compare = 1'b0;
    w_error   = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    w_iterative = 1'b0;
`endif
    case (func)
      c_funcAdd:  w_result  = dataIn1 + dataIn2;
      c_funcSub:  w_result  = dataIn1 - dataIn2;
      c_funcAnd:  w_result  = dataIn1 & dataIn2;
      c_funcOr:   w_result  = dataIn1 | dataIn2;
      c_funcXor:  w_result  = dataIn1 ^ dataIn2;
      c_funcNand: w_result  = ~(dataIn1 & dataIn2);
      c_funcNor:  w_result  = ~(dataIn1 | dataIn2);
      c_funcXnor: w_result  = ~(dataIn1 ^ dataIn2);
      c_funcF:    w_compare = 1'b0;
      c_funcEq:   w_compare = w_equal;
      c_funcLt:   w_compare = w_lessThan;
      c_funcLte:  w_compare = w_lessThan | w_equal;
      c_funcT:    w_compare = 1'b1;
      c_funcNe:   w_compare = ~w_equal;
      c_funcGte:  w_compare = ~w_lessThan;
      c_funcGt:   w_compare = ~(w_lessThan | w_equal);
`ifdef ALU_SEQ_MULDIV_EN
      c_funcMul:  w_iterative = 1'b1;
      c_funcDivu, c_funcRemu: begin
        // A zero divisor never enters the iterative loop: the result is
        // fixed (all-ones quotient, remainder = dividend) and flagged.
        if (dataIn2 == '0) begin
          w_error  = 1'b1;
          w_result = (func == c_funcDivu) ? {BIT_WIDTH{1'b1}} : dataIn1;
        end else begin
          w_iterative = 1'b1;
        end
      end
`endif
      default:    w_error = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  // --------------------------------------------------------------------------
  // Iterative datapath, shared between multiply and divide.
  //   Multiply: r_opA = shifted multiplicand, r_opB = multiplier consumed
  //             LSB-first, r_acc = running product (low bits only).
  //   Divide  : r_opA = dividend shifting out MSB-first while quotient bits
  //             shift in, r_opB = divisor, r_acc = partial remainder.
  // --------------------------------------------------------------------------
  logic [BIT_WIDTH-1:0] r_opA;
  logic [BIT_WIDTH-1:0] r_opB;
  logic [BIT_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_count;
  logic                 r_isDiv;
  logic                 r_isRem;

  logic [BIT_WIDTH:0]   w_partial;
  logic                 w_quoBit;
  logic [BIT_WIDTH-1:0] w_opANext;
  logic [BIT_WIDTH-1:0] w_opBNext;
  logic [BIT_WIDTH-1:0] w_accNext;
  logic [BIT_WIDTH-1:0] w_iterResult;

  always_comb begin
    // Partial remainder is always below the divisor, so shifting it left by
    // one plus the next dividend bit needs one extra bit of headroom.
    w_partial = {r_acc, r_opA[BIT_WIDTH-1]};
    w_quoBit  = 1'b0;
    w_opANext = r_opA;
    w_opBNext = r_opB;
    w_accNext = r_acc;
    if (r_isDiv) begin
      w_quoBit  = (w_partial >= {1'b0, r_opB});
      // After a successful subtract the difference is below the divisor, so
      // the truncated subtraction is exact.
      w_accNext = w_quoBit ? (w_partial[BIT_WIDTH-1:0] - r_opB)
                           : w_partial[BIT_WIDTH-1:0];
      w_opANext = {r_opA[BIT_WIDTH-2:0], w_quoBit};
    end else begin
      w_accNext = r_acc + (r_opB[0] ? r_opA : '0);
      w_opANext = r_opA << 1;
      w_opBNext = r_opB >> 1;
    end
    w_iterResult = (r_isDiv && !r_isRem) ? w_opANext : w_accNext;
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_dataOut  <= '0;
      r_compTrue <= 1'b0;
      r_err      <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      r_opA      <= '0;
      r_opB      <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_isDiv    <= 1'b0;
      r_isRem    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (inValid) begin
            r_inReady <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            if (w_iterative) begin
              r_state <= BUSY;
              r_opA   <= dataIn1;
              r_opB   <= dataIn2;
              r_acc   <= '0;
              r_count <= CNT_W'(BIT_WIDTH);
              // func[1] separates DIVU/REMU from MUL, func[0] REMU from DIVU
              r_isDiv <= func[1];
              r_isRem <= func[0];
            end else
`endif
            begin
              r_state    <= DONE;
              r_outValid <= 1'b1;
              r_dataOut  <= w_result;
              r_compTrue <= w_compare;
              r_err      <= w_error;
            end
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          r_opA   <= w_opANext;
          r_opB   <= w_opBNext;
          r_acc   <= w_accNext;
          r_count <= r_count - CNT_W'(1);
          // The last iteration's result goes straight to the output register
          // so the result is visible as soon as the counter hits zero.
          if (r_count == CNT_W'(1)) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
            r_dataOut  <= w_iterResult;
            r_compTrue <= 1'b0;
            r_err      <= 1'b0;
          end
        end
`endif
        DONE: begin
          // Consuming the result only returns to IDLE; a request presented
          // on this same edge is not taken.
          if (outReady) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (BIT_WIDTH=32). A transaction
//            level reference model predicts handshake timing and results and
//            is compared against the DUT every cycle; directed cases pin the
//            model with hand-computed values. Follows ALU_SEQ_MULDIV_EN.
// Revision : 1.0 - first release
// ============================================================================
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif
  localparam int ITER_LAT = MULDIV ? W + 1 : 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         inValid = 1'b0;
  logic         outReady = 1'b0;
  logic [4:0]   func = '0;
  logic [W-1:0] dataIn1 = '0;
  logic [W-1:0] dataIn2 = '0;
  logic         inReady;
  logic         outValid;
  logic [W-1:0] dataOut;
  logic         compTrue;
  logic         err;

  int total = 0;
  int bad   = 0;

  alu_seq #(.BIT_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .func     (func),
    .dataIn1  (dataIn1),
    .dataIn2  (dataIn2),
    .outValid (outValid),
    .outReady (outReady),
    .dataOut  (dataOut),
    .compTrue (compTrue),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: what an operation must produce, straight from the op table.
  function automatic void refOp(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic c, output logic e,
                                output int lat);
    d = '0; c = 1'b0; e = 1'b0; lat = 1;
    case (f)
      5'b00000: d = a + b;
      5'b00001: d = a - b;
      5'b00100: d = a & b;
      5'b00101: d = a | b;
      5'b00110: d = a ^ b;
      5'b01100: d = ~(a & b);
      5'b01101: d = ~(a | b);
      5'b01110: d = ~(a ^ b);
      5'b10000: c = 1'b0;
      5'b10001: c = (a == b);
      5'b10010: c = ($signed(a) <  $signed(b));
      5'b10011: c = ($signed(a) <= $signed(b));
      5'b11000: c = 1'b1;
      5'b11001: c = (a != b);
      5'b11010: c = ($signed(a) >= $signed(b));
      5'b11011: c = ($signed(a) >  $signed(b));
      5'b01000: begin
        if (MULDIV) begin d = a * b; lat = W + 1; end
        else e = 1'b1;
      end
      5'b01010, 5'b01011: begin
        if (!MULDIV) e = 1'b1;
        else if (b == '0) begin
          e = 1'b1;
          d = (f == 5'b01010) ? '1 : a;
        end else begin
          d = (f == 5'b01010) ? a / b : a % b;
          lat = W + 1;
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  // Transaction model: idle / waiting for a result / holding a result.
  logic         mBusy = 1'b0;
  logic         mHave = 1'b0;
  int           mLeft = 0;
  logic [W-1:0] mData = '0;
  logic         mCmp = 1'b0;
  logic         mErr = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [W-1:0] d;
    logic c, e;
    int l;
    if (reset) begin
      mBusy <= 1'b0;
      mHave <= 1'b0;
      mLeft <= 0;
    end else if (mHave) begin
      if (outReady) mHave <= 1'b0;
    end else if (mBusy) begin
      if (mLeft == 1) begin
        mBusy <= 1'b0;
        mHave <= 1'b1;
      end
      mLeft <= mLeft - 1;
    end else if (inValid) begin
      refOp(func, dataIn1, dataIn2, d, c, e, l);
      mData <= d;
      mCmp  <= c;
      mErr  <= e;
      if (l == 1) mHave <= 1'b1;
      else begin
        mBusy <= 1'b1;
        mLeft <= l - 1;
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("inReady", W'(inReady), W'(!(mBusy || mHave)));
      chk("outValid", W'(outValid), W'(mHave));
      if (mHave) begin
        chk("dataOut", dataOut, mData);
        chk("compTrue", W'(compTrue), W'(mCmp));
        chk("err", W'(err), W'(mErr));
      end
    end
  end

  task automatic junk();
    inValid = 1'($urandom);
    func    = 5'($urandom);
    dataIn1 = $urandom;
    dataIn2 = $urandom;
  endtask

  // Issue one op, scramble inputs while it runs, hold the result 'hold'
  // cycles under backpressure, then consume it.
  task automatic runOp(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, output logic [W-1:0] gotD, output logic gotC,
                       output logic gotE, output int lat);
    @(negedge clk);
    inValid = 1'b1; func = f; dataIn1 = a; dataIn2 = b; outReady = 1'b0;
    @(posedge clk); #1;
    junk();
    lat = 1;
    while (!outValid && lat <= 200) begin
      @(posedge clk); #1;
      junk();
      lat++;
    end
    if (!outValid) begin
      total++; bad++;
      $display("FAIL timeout func=%b got=no outValid exp=outValid within 200 cycles", f);
    end
    gotD = dataOut; gotC = compTrue; gotE = err;
    repeat (hold) begin
      @(posedge clk); #1;
      junk();
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    inValid  = 1'b0;
  endtask

  task automatic dirOp(input string name, input logic [4:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expD, input logic expC,
                       input logic expE, input int expLat, input int hold);
    logic [W-1:0] d;
    logic c, e;
    int lat;
    runOp(f, a, b, hold, d, c, e, lat);
    chk({name, ".data"}, d, expD);
    chk({name, ".cmp"}, W'(c), W'(expC));
    chk({name, ".err"}, W'(e), W'(expE));
    chk({name, ".lat"}, W'(lat), W'(expLat));
    chk({name, ".inReady"}, W'(inReady), W'(1));
  endtask

  logic [4:0] codes [19] = '{5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b00110,
                             5'b01100, 5'b01101, 5'b01110, 5'b10000, 5'b10001,
                             5'b10010, 5'b10011, 5'b11000, 5'b11001, 5'b11010,
                             5'b11011, 5'b01000, 5'b01010, 5'b01011};

  initial begin
    logic [W-1:0] a, b, d;
    logic [4:0] f;
    logic c, e;
    int lat;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.outValid", W'(outValid), W'(0));
    chk("rst.inReady", W'(inReady), W'(1));
    chk("rst.dataOut", dataOut, '0);
    chk("rst.compTrue", W'(compTrue), W'(0));
    chk("rst.err", W'(err), W'(0));

    dirOp("add", 5'b00000, 2, 3, 5, 0, 0, 1, 0);
    dirOp("sub", 5'b00001, 5, 2, 3, 0, 0, 1, 0);
    dirOp("subWrap", 5'b00001, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, 1);
    dirOp("eqT", 5'b10001, 2, 2, 0, 1, 0, 1, 0);
    dirOp("eqF", 5'b10001, 2, 3, 0, 0, 0, 1, 0);
    dirOp("ltSigned", 5'b10010, 32'hFFFF_FFFF, 1, 0, 1, 0, 1, 0);
    dirOp("gtSigned", 5'b11011, 1, 32'hFFFF_FFFF, 0, 1, 0, 1, 0);
    dirOp("xnor", 5'b01110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF00F_F00F, 0, 0, 1, 0);
    dirOp("mul", 5'b01000, 7, 6, MULDIV ? 42 : 0, 0, !MULDIV, ITER_LAT, 0);
    dirOp("divu", 5'b01010, 100, 7, MULDIV ? 14 : 0, 0, !MULDIV, ITER_LAT, 0);
    dirOp("remu", 5'b01011, 100, 7, MULDIV ? 2 : 0, 0, !MULDIV, ITER_LAT, 2);
    dirOp("divZero", 5'b01010, 5, 0, MULDIV ? 32'hFFFF_FFFF : 0, 0, 1, 1, 0);
    dirOp("remZero", 5'b01011, 5, 0, MULDIV ? 5 : 0, 0, 1, 1, 0);
    dirOp("undef", 5'b00111, 9, 9, 0, 0, 1, 1, 0);
    dirOp("backpress", 5'b00000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 1, 5);

    // Reset in the middle of an iterative op discards it.
    @(negedge clk);
    inValid = 1'b1; func = 5'b01000; dataIn1 = 7; dataIn2 = 6;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midRst.outValid", W'(outValid), W'(0));
    chk("midRst.inReady", W'(inReady), W'(1));
    chk("midRst.dataOut", dataOut, '0);
    chk("midRst.err", W'(err), W'(0));
    @(negedge clk);
    reset = 1'b0;
    dirOp("addAfterRst", 5'b00000, 1, 1, 2, 0, 0, 1, 0);

    // Randomized ops, checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) f = 5'($urandom);
      else f = codes[$urandom_range(0, 18)];
      case ($urandom_range(0, 3))
        0: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
        1: begin a = $urandom; b = $urandom_range(0, 3); end
        2: begin a = $urandom; b = $urandom_range(0, 1) ? a : ~a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      runOp(f, a, b, $urandom_range(0, 3), d, c, e, lat);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=still running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
